mii_rx_byte_assembler: RTL and testbench
========================================

MII_RX_BYTE_ASSEMBLER -- requirements
Module: mii_rx_byte_assembler

Interface
REQ-001 SHALL have parameter p_MIN_FRAME_BYTES, default 64: minimum good frame length in bytes, after SFD, including FCS.
REQ-002 SHALL have parameter p_MAX_FRAME_BYTES, default 1522: maximum good frame length in bytes, after SFD, including FCS.
REQ-003 SHALL have port i_clock, input, 1 bit: MII RX clock (PHY rx_clk, 25 MHz); the only clock.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_rx_d, input, 4 bits: MII receive nibble, least-significant nibble first.
REQ-006 SHALL have port i_rx_dv, input, 1 bit: MII receive data valid.
REQ-007 SHALL have port i_rx_er, input, 1 bit: MII receive error.
REQ-008 SHALL have port o_m_axis_tdata, output, 8 bits: assembled frame byte.
REQ-009 SHALL have port o_m_axis_tvalid, output, 1 bit: byte valid, one-cycle pulse; no tready (MII cannot be stalled).
REQ-010 SHALL have port o_m_axis_tlast, output, 1 bit: last byte of frame, qualified by tvalid.
REQ-011 SHALL have port o_m_axis_tuser, output, 1 bit: frame bad, valid only with tlast.
REQ-012 SHALL have port o_good_frames, output, 16 bits: saturating count of frames ended with tuser=0.
REQ-013 SHALL have port o_bad_frames, output, 16 bits: saturating count of bad or dropped frames.

Function
REQ-014 SHALL register i_rx_d, i_rx_dv and i_rx_er in one input stage; all decisions use the registered values.
REQ-015 SHALL implement FSM states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: dv=1 with d=0x5 -> PREAMBLE; dv=1 with any other d -> DROP, counted bad; dv=0 with er=1 (carrier extension/false carrier) ignored.
REQ-017 PREAMBLE: d=0x5 -> stay; d=0xD -> DATA (SFD, nibble phase reset to low); any other d, or er=1 -> DROP, counted bad; dv=0 -> IDLE, not counted.
REQ-018 DATA: first nibble -> byte[3:0], second -> byte[7:4]; each completed byte goes to a one-byte hold register; the previously held byte is emitted one cycle later with tvalid=1, tlast=0.
REQ-019 DATA, dv falls: held byte emitted next cycle with tvalid=1, tlast=1; -> IDLE.
REQ-020 tuser=1 at tlast if any of: er=1 seen in DATA; odd nibble count (trailing nibble discarded); byte count < p_MIN_FRAME_BYTES.
REQ-021 Byte count reaches p_MAX_FRAME_BYTES with dv still high: that byte emitted with tlast=1, tuser=1; -> DROP until dv=0; remaining nibbles discarded.
REQ-022 SFD immediately followed by dv=0 (zero bytes): no output beat; o_bad_frames increments.
REQ-023 DROP: no output; dv=0 -> IDLE.
REQ-024 Counters SHALL increment exactly once per frame, in the cycle of the tlast beat or drop decision, and hold at 0xFFFF.
REQ-025 Byte counter SHALL be 16 bits wide and saturating.
REQ-026 Consecutive tvalid beats SHALL be at least 2 cycles apart; back-to-back frames with a 1-cycle dv-low gap SHALL both be received.

Reset
REQ-027 While i_reset=1: o_m_axis_tdata=0x00, tvalid=0, tlast=0, tuser=0, counters=0, FSM=IDLE, hold register empty, input stage cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no tlast and no count.
REQ-029 If dv=1 in the first registered cycle after reset release, the FSM SHALL go to DROP without counting until dv=0.

Verification
REQ-030 Stimulus: 15 nibbles 0x5, 0xD, then 64 bytes 0x00..0x3F, then dv=0 -> Required: 64 beats, data 0x00..0x3F, tlast only on 0x3F, tuser=0, o_good_frames=1.
REQ-031 Stimulus: the same frame with er=1 on byte 10 -> Required: 64 beats, tlast tuser=1, o_bad_frames=1, o_good_frames unchanged.
REQ-032 Stimulus: a 40-byte frame; separately, a 64-byte frame plus one extra nibble -> Required: both end with tuser=1 (short and odd respectively), o_bad_frames=2.
REQ-033 Stimulus: a 1600-byte frame -> Required: exactly 1522 beats, beat 1522 has tlast=1 and tuser=1, no further beats until the next preamble.
REQ-034 Stimulus: preamble 0x5 0x5 0x7 -> Required: DROP, no beats, o_bad_frames+1; a following good frame after a 1-cycle dv gap is received correctly.
REQ-035 Stimulus: i_reset pulsed at byte 30 of a frame while dv stays high -> Required: outputs 0 immediately, no tlast, counters 0, next frame received normally.

Source files
------------

// File: rtl/mii_rx_byte_assembler.sv
// MII receive nibble-to-byte assembler: strips preamble/SFD, builds bytes LS nibble first,
// and streams them as one-cycle beats with end-of-frame status and frame counters.
module mii_rx_byte_assembler #(
  parameter int unsigned p_MIN_FRAME_BYTES = 64,
  parameter int unsigned p_MAX_FRAME_BYTES = 1522
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [3:0]  i_rx_d,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  output logic [7:0]  o_m_axis_tdata,
  output logic        o_m_axis_tvalid,
  output logic        o_m_axis_tlast,
  output logic        o_m_axis_tuser,
  output logic [15:0] o_good_frames,
  output logic [15:0] o_bad_frames
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] MIN_BYTES = CNT_W'(p_MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(p_MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       rx_d_q;
  logic             rx_dv_q, rx_er_q, stage_vld_q;
  logic             sync_ok_q, sync_ok_d;
  logic             phase_q, phase_d;
  logic [3:0]       lo_q, lo_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d, pend_bad_q, pend_bad_d;
  logic [7:0]       tdata_d;
  logic             tvalid_d, tlast_d, tuser_d;
  logic             good_inc;
  logic [1:0]       bad_inc;
  logic [CNT_W-1:0] good_d, bad_d;
  logic [CNT_W:0]   bad_sum;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state, byte assembly and beat generation; the end-of-frame beat waits in
  // pend_q until the previous beat is at least two cycles old.
  always_comb begin
    state_d    = state_q;
    sync_ok_d  = sync_ok_q | (stage_vld_q & ~rx_dv_q);
    phase_d    = phase_q;
    lo_d       = lo_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    pend_d     = pend_q;
    pend_bad_d = pend_bad_q;
    tdata_d    = o_m_axis_tdata;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    good_inc   = 1'b0;
    bad_inc    = 2'd0;

    if (pend_q && !o_m_axis_tvalid) begin
      tvalid_d   = 1'b1;
      tlast_d    = 1'b1;
      tuser_d    = pend_bad_q;
      tdata_d    = hold_q;
      pend_d     = 1'b0;
      hold_vld_d = 1'b0;
      if (pend_bad_q) bad_inc = bad_inc + 2'd1;
      else            good_inc = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_dv_q) begin
          if (!sync_ok_q) begin
            // joined mid-frame after reset: discard silently
            state_d = S_DROP;
          end else if (rx_d_q == 4'h5) begin
            state_d = S_PREAMBLE;
          end else begin
            state_d = S_DROP;
            bad_inc = bad_inc + 2'd1;
          end
        end
      end
      S_PREAMBLE: begin
        if (!rx_dv_q) begin
          state_d = S_IDLE;
        end else if (rx_er_q || (rx_d_q != 4'h5 && rx_d_q != 4'hD)) begin
          state_d = S_DROP;
          bad_inc = bad_inc + 2'd1;
        end else if (rx_d_q == 4'hD) begin
          state_d    = S_DATA;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          hold_vld_d = 1'b0;
        end
      end
      S_DATA: begin
        if (!rx_dv_q) begin
          state_d = S_IDLE;
          if (byte_cnt_q == '0) begin
            bad_inc = bad_inc + 2'd1;
          end else begin
            pend_d     = 1'b1;
            pend_bad_d = err_q | phase_q | (byte_cnt_q < MIN_BYTES);
          end
        end else begin
          if (rx_er_q) err_d = 1'b1;
          if (!phase_q) begin
            lo_d    = rx_d_q;
            phase_d = 1'b1;
          end else begin
            phase_d    = 1'b0;
            hold_d     = {rx_d_q, lo_q};
            hold_vld_d = 1'b1;
            if (hold_vld_q) begin
              tvalid_d = 1'b1;
              tdata_d  = hold_q;
            end
            if (byte_cnt_q != CNT_SAT) byte_cnt_d = byte_cnt_q + 16'd1;
            if (byte_cnt_d == MAX_BYTES) begin
              state_d    = S_DROP;
              pend_d     = 1'b1;
              pend_bad_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (!rx_dv_q) state_d = S_IDLE;
      end
    endcase

    good_d  = (good_inc && o_good_frames != CNT_SAT) ? o_good_frames + 16'd1 : o_good_frames;
    bad_sum = 17'(o_bad_frames) + 17'(bad_inc);
    bad_d   = bad_sum[CNT_W] ? CNT_SAT : bad_sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_d_q          <= '0;
      rx_dv_q         <= 1'b0;
      rx_er_q         <= 1'b0;
      stage_vld_q     <= 1'b0;
      sync_ok_q       <= 1'b0;
      phase_q         <= 1'b0;
      lo_q            <= '0;
      hold_q          <= '0;
      hold_vld_q      <= 1'b0;
      byte_cnt_q      <= '0;
      err_q           <= 1'b0;
      pend_q          <= 1'b0;
      pend_bad_q      <= 1'b0;
      o_m_axis_tdata  <= '0;
      o_m_axis_tvalid <= 1'b0;
      o_m_axis_tlast  <= 1'b0;
      o_m_axis_tuser  <= 1'b0;
      o_good_frames   <= '0;
      o_bad_frames    <= '0;
    end else begin
      rx_d_q          <= i_rx_d;
      rx_dv_q         <= i_rx_dv;
      rx_er_q         <= i_rx_er;
      stage_vld_q     <= 1'b1;
      sync_ok_q       <= sync_ok_d;
      phase_q         <= phase_d;
      lo_q            <= lo_d;
      hold_q          <= hold_d;
      hold_vld_q      <= hold_vld_d;
      byte_cnt_q      <= byte_cnt_d;
      err_q           <= err_d;
      pend_q          <= pend_d;
      pend_bad_q      <= pend_bad_d;
      o_m_axis_tdata  <= tdata_d;
      o_m_axis_tvalid <= tvalid_d;
      o_m_axis_tlast  <= tlast_d;
      o_m_axis_tuser  <= tuser_d;
      o_good_frames   <= good_d;
      o_bad_frames    <= bad_d;
    end
  end

endmodule

// File: tb/tb_mii_rx_byte_assembler.sv
// Directed bench for mii_rx_byte_assembler: drives MII nibbles, collects beats, checks
// beat contents, frame status and counters against hand-derived expectations.
module tb_mii_rx_byte_assembler;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [3:0]  i_rx_d;
  logic        i_rx_dv;
  logic        i_rx_er;
  logic [7:0]  o_m_axis_tdata;
  logic        o_m_axis_tvalid;
  logic        o_m_axis_tlast;
  logic        o_m_axis_tuser;
  logic [15:0] o_good_frames;
  logic [15:0] o_bad_frames;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_data[$];
  bit         q_last[$];
  bit         q_user[$];
  int         cyc = 0;
  int         last_beat_cyc = -1000;
  int         min_gap = 1000;

  mii_rx_byte_assembler #(
    .p_MIN_FRAME_BYTES(64),
    .p_MAX_FRAME_BYTES(1522)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_rx_d         (i_rx_d),
    .i_rx_dv        (i_rx_dv),
    .i_rx_er        (i_rx_er),
    .o_m_axis_tdata (o_m_axis_tdata),
    .o_m_axis_tvalid(o_m_axis_tvalid),
    .o_m_axis_tlast (o_m_axis_tlast),
    .o_m_axis_tuser (o_m_axis_tuser),
    .o_good_frames  (o_good_frames),
    .o_bad_frames   (o_bad_frames)
  );

  always #5 i_clock = ~i_clock;

  // Beat collector, sampling away from the active edge
  always @(negedge i_clock) begin
    cyc++;
    if (o_m_axis_tvalid) begin
      q_data.push_back(o_m_axis_tdata);
      q_last.push_back(o_m_axis_tlast);
      q_user.push_back(o_m_axis_tuser);
      if (cyc - last_beat_cyc < min_gap) min_gap = cyc - last_beat_cyc;
      last_beat_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nib(input logic [3:0] d, input logic dv, input logic er);
    @(negedge i_clock);
    i_rx_d  = d;
    i_rx_dv = dv;
    i_rx_er = er;
  endtask

  task automatic preamble();
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b1, 1'b0);
    nib(4'hD, 1'b1, 1'b0);
  endtask

  task automatic send_bytes(input int first, input int last, input logic [7:0] start, input int er_byte);
    for (int i = first; i <= last; i++) begin
      logic [7:0] b;
      b = start + 8'(i);
      nib(b[3:0], 1'b1, 1'(i == er_byte));
      nib(b[7:4], 1'b1, 1'(i == er_byte));
    end
  endtask

  task automatic send_frame(input int len, input logic [7:0] start, input int er_byte,
                            input bit extra_nib, input int gap);
    preamble();
    send_bytes(0, len - 1, start, er_byte);
    if (extra_nib) nib(4'hA, 1'b1, 1'b0);
    repeat (gap) nib(4'h0, 1'b0, 1'b0);
  endtask

  // Beat i carries start+i; tlast on every frame_len-th beat, where tuser must equal user_exp
  task automatic check_beats(input string tag, input int n_exp, input logic [7:0] start,
                             input int frame_len, input bit user_exp);
    int bad_d, bad_l, bad_u, n;
    logic [7:0] exp_d;
    bit exp_l;
    @(posedge i_clock);
    #1;
    bad_d = 0; bad_l = 0; bad_u = 0;
    n = q_data.size();
    chk({tag, " beats"}, 32'(n), 32'(n_exp));
    if (n_exp > 0) begin
      for (int i = 0; i < n && i < n_exp; i++) begin
        exp_d = start + 8'(i);
        exp_l = ((i + 1) % frame_len) == 0;
        if (q_data[i] !== exp_d) bad_d++;
        if (q_last[i] !== exp_l) bad_l++;
        if (exp_l && q_user[i] !== user_exp) bad_u++;
      end
      chk({tag, " data_errs"}, 32'(bad_d), 32'd0);
      chk({tag, " tlast_errs"}, 32'(bad_l), 32'd0);
      chk({tag, " tuser_errs"}, 32'(bad_u), 32'd0);
    end
    q_data.delete();
    q_last.delete();
    q_user.delete();
  endtask

  task automatic chk_counts(input string tag, input int good, input int bad);
    chk({tag, " good"}, 32'(o_good_frames), 32'(good));
    chk({tag, " bad"}, 32'(o_bad_frames), 32'(bad));
  endtask

  initial begin
    i_reset = 1'b1;
    i_rx_d  = 4'h0;
    i_rx_dv = 1'b0;
    i_rx_er = 1'b0;
    repeat (3) @(negedge i_clock);
    chk("rst tdata", 32'(o_m_axis_tdata), 32'h0);
    chk("rst tvalid", 32'(o_m_axis_tvalid), 32'h0);
    chk("rst tlast", 32'(o_m_axis_tlast), 32'h0);
    chk("rst tuser", 32'(o_m_axis_tuser), 32'h0);
    chk_counts("rst", 0, 0);
    i_reset = 1'b0;
    repeat (4) nib(4'h0, 1'b0, 1'b0);

    send_frame(64, 8'h00, -1, 1'b0, 8);
    check_beats("good64", 64, 8'h00, 64, 1'b0);
    chk_counts("good64", 1, 0);

    send_frame(64, 8'h00, 10, 1'b0, 8);
    check_beats("err10", 64, 8'h00, 64, 1'b1);
    chk_counts("err10", 1, 1);

    send_frame(40, 8'h00, -1, 1'b0, 8);
    check_beats("short40", 40, 8'h00, 40, 1'b1);
    chk_counts("short40", 1, 2);

    send_frame(64, 8'h00, -1, 1'b1, 8);
    check_beats("odd64", 64, 8'h00, 64, 1'b1);
    chk_counts("odd64", 1, 3);

    send_frame(63, 8'h00, -1, 1'b0, 8);
    check_beats("min63", 63, 8'h00, 63, 1'b1);
    chk_counts("min63", 1, 4);

    send_frame(1600, 8'h00, -1, 1'b0, 8);
    check_beats("max1522", 1522, 8'h00, 1522, 1'b1);
    chk_counts("max1522", 1, 5);

    // Bad preamble, then a good frame after a single idle cycle
    nib(4'h5, 1'b1, 1'b0);
    nib(4'h5, 1'b1, 1'b0);
    nib(4'h7, 1'b1, 1'b0);
    repeat (5) nib(4'hA, 1'b1, 1'b0);
    nib(4'h0, 1'b0, 1'b0);
    send_frame(64, 8'h00, -1, 1'b0, 8);
    check_beats("after_drop", 64, 8'h00, 64, 1'b0);
    chk_counts("after_drop", 2, 6);

    // Back-to-back frames, 1-cycle dv-low gap
    send_frame(64, 8'h00, -1, 1'b0, 1);
    send_frame(64, 8'h40, -1, 1'b0, 8);
    check_beats("b2b", 128, 8'h00, 64, 1'b0);
    chk_counts("b2b", 4, 6);

    // SFD followed directly by dv low
    preamble();
    repeat (8) nib(4'h0, 1'b0, 1'b0);
    check_beats("zero", 0, 8'h00, 1, 1'b0);
    chk_counts("zero", 4, 7);

    chk("min_gap_ge_2", 32'(min_gap >= 2), 32'd1);

    // Reset in the middle of byte 30 with dv held high
    preamble();
    send_bytes(0, 29, 8'h00, -1);
    nib(4'hE, 1'b1, 1'b0);
    #2 i_reset = 1'b1;
    #1;
    chk("midrst tdata", 32'(o_m_axis_tdata), 32'h0);
    chk("midrst tvalid", 32'(o_m_axis_tvalid), 32'h0);
    chk("midrst tlast", 32'(o_m_axis_tlast), 32'h0);
    chk_counts("midrst", 0, 0);
    q_data.delete();
    q_last.delete();
    q_user.delete();
    nib(4'h1, 1'b1, 1'b0);
    send_bytes(31, 32, 8'h00, -1);
    i_reset = 1'b0;
    send_bytes(33, 63, 8'h00, -1);
    repeat (8) nib(4'h0, 1'b0, 1'b0);
    check_beats("rst_abort", 0, 8'h00, 1, 1'b0);
    chk_counts("rst_abort", 0, 0);

    send_frame(64, 8'h00, -1, 1'b0, 8);
    check_beats("post_rst", 64, 8'h00, 64, 1'b0);
    chk_counts("post_rst", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
